// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner selection for a shared 4-digit display.
// One of three requesters owns the display for at most HOLD_CYCLES cycles,
// followed by BLANK_CYCLES of blanking before the next owner is chosen in IDLE.
// All outputs are registered; ack pulses for one cycle when an ownership ends.
module display_arbiter #(
  parameter logic [31:0] HOLD_CYCLES  = 32'd50000000,
  parameter logic [31:0] BLANK_CYCLES = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic [15:0] digits,
  output logic        blank,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  ack_q, ack_d;
  logic [15:0] digits_q, digits_d;
  logic        blank_q, blank_d;
  logic        busy_q, busy_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] blank_cnt_q, blank_cnt_d;

  logic        win_valid;
  logic [1:0]  win_idx;

  // Digit codes are forwarded untouched, including values above 9.
  function automatic logic [15:0] sel_data(input logic [1:0] idx,
                                           input logic [15:0] d0,
                                           input logic [15:0] d1,
                                           input logic [15:0] d2);
    case (idx)
      2'd0:    sel_data = d0;
      2'd1:    sel_data = d1;
      2'd2:    sel_data = d2;
      default: sel_data = 16'h0000;
    endcase
  endfunction

  // Round-robin pick: scan last+3, last+2, last+1 so the closest successor wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      int cand;
      cand = (int'(last_q) + k) % 3;
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = 2'(cand);
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/SHOW/BLANK FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = 3'b000;
    digits_d    = digits_q;
    blank_d     = blank_q;
    busy_d      = busy_q;
    last_d      = last_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_d  = 3'b000;
        digits_d = 16'h0000;
        blank_d  = 1'b1;
        busy_d   = 1'b0;
        if (win_valid) begin
          state_d    = ST_SHOW;
          grant_d    = 3'b001 << win_idx;
          owner_d    = win_idx;
          last_d     = win_idx;
          digits_d   = sel_data(win_idx, data0, data1, data2);
          hold_cnt_d = HOLD_CYCLES - 32'd1;
          blank_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_SHOW: begin
        // Expiry and release may coincide; both take this single exit path,
        // so only one ack pulse is produced.
        if ((hold_cnt_q == 32'd0) || !req[owner_q]) begin
          state_d     = ST_BLANK;
          ack_d       = grant_q;
          grant_d     = 3'b000;
          digits_d    = 16'h0000;
          blank_d     = 1'b1;
          busy_d      = 1'b1;
          blank_cnt_d = BLANK_CYCLES - 32'd1;
        end else begin
          digits_d   = sel_data(owner_q, data0, data1, data2);
          blank_d    = 1'b0;
          hold_cnt_d = hold_cnt_q - 32'd1;
        end
      end
      ST_BLANK: begin
        grant_d  = 3'b000;
        digits_d = 16'h0000;
        blank_d  = 1'b1;
        if (blank_cnt_q == 32'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          blank_cnt_d = blank_cnt_q - 32'd1;
          busy_d      = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = 3'b000;
        digits_d = 16'h0000;
        blank_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any ownership without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
      digits_q    <= 16'h0000;
      blank_q     <= 1'b1;
      busy_q      <= 1'b0;
      last_q      <= 2'd2;
      owner_q     <= 2'd0;
      hold_cnt_q  <= 32'd0;
      blank_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign digits    = digits_q;
  assign blank     = blank_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4, BLANK_CYCLES=2.
// Observed vector layout: {grant, ack, digits, blank, busy}.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant, ack;
  logic [15:0] digits;
  logic        blank, busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [23:0] obs, exp;

  display_arbiter #(.HOLD_CYCLES(32'd4), .BLANK_CYCLES(32'd2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .ack(ack), .digits(digits),
    .blank(blank), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release just after the last one
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b111; data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
      obs = {grant, ack, digits, blank, busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_hold%0d got %h want %h", c, obs, exp); end
      checks++;
      if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state%0d got %0d want 0", c, state_dbg); end
    end
  endtask

  task automatic test_single();
    req = 3'b001; data0 = 16'h1234;
    do_reset();
    tick(); // grant edge
    for (int c = 0; c < 4; c++) begin
      exp = {3'b001, 3'b000, 16'h1234, 1'b0, 1'b1};
      obs = {grant, ack, digits, blank, busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_show%0d got %h want %h", c, obs, exp); end
      tick();
    end
    exp = {3'b000, 3'b001, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_ack got %h want %h", obs, exp); end
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_blank2 got %h want %h", obs, exp); end
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_idle got %h want %h", obs, exp); end
    tick();
    exp = {3'b001, 3'b000, 16'h1234, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_regrant got %h want %h", obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  g_seq [4];
    logic [15:0] d_seq [4];
    g_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    d_seq = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
    req = 3'b111; data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        exp = {g_seq[k], 3'b000, d_seq[k], 1'b0, 1'b1};
        obs = {grant, ack, digits, blank, busy};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL rr_show%0d_%0d got %h want %h", k, c, obs, exp); end
        tick();
      end
      exp = {3'b000, g_seq[k], 16'h0000, 1'b1, 1'b1};
      obs = {grant, ack, digits, blank, busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_ack%0d got %h want %h", k, obs, exp); end
      tick();
      exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
      obs = {grant, ack, digits, blank, busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_blank%0d got %h want %h", k, obs, exp); end
      tick();
      exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
      obs = {grant, ack, digits, blank, busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_idle%0d got %h want %h", k, obs, exp); end
      tick();
    end
  endtask

  task automatic test_early_release();
    req = 3'b010; data1 = 16'hABCD;
    do_reset();
    tick();
    exp = {3'b010, 3'b000, 16'hABCD, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL early_grant got %h want %h", obs, exp); end
    tick();
    req = 3'b000; // dropped in the 2nd SHOW cycle
    tick();
    exp = {3'b000, 3'b010, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL early_ack got %h want %h", obs, exp); end
    checks++;
    if (state_dbg !== 2'd2) begin errors++; $display("FAIL early_state got %0d want 2", state_dbg); end
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL early_blank got %h want %h", obs, exp); end
  endtask

  task automatic test_live_update();
    req = 3'b100; data2 = 16'h0009; data0 = 16'h0000;
    do_reset();
    tick();
    exp = {3'b100, 3'b000, 16'h0009, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL live_grant got %h want %h", obs, exp); end
    data2 = 16'h00FA;
    req = 3'b111; // other requesters must not preempt
    data0 = 16'h5555;
    tick();
    exp = {3'b100, 3'b000, 16'h00FA, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL live_update got %h want %h", obs, exp); end
    tick();
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL live_nopreempt got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid_show();
    req = 3'b001; data0 = 16'h4321; data1 = 16'h0777;
    do_reset();
    tick();
    tick();
    tick();
    exp = {3'b001, 3'b000, 16'h4321, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_show got %h want %h", obs, exp); end
    rst = 1'b1; // 3rd SHOW cycle
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_abort got %h want %h", obs, exp); end
    rst = 1'b0;
    req = 3'b110;
    tick();
    exp = {3'b010, 3'b000, 16'h0777, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_first_grant got %h want %h", obs, exp); end
  endtask

  task automatic test_simultaneous();
    req = 3'b001; data0 = 16'h0F0F;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    exp = {3'b001, 3'b000, 16'h0F0F, 1'b0, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL simul_last_show got %h want %h", obs, exp); end
    req = 3'b000; // drop coincides with hold expiry
    tick();
    exp = {3'b000, 3'b001, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL simul_ack got %h want %h", obs, exp); end
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL simul_blank got %h want %h", obs, exp); end
    tick();
    exp = {3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL simul_idle got %h want %h", obs, exp); end
    tick();
    obs = {grant, ack, digits, blank, busy};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL simul_stay_idle got %h want %h", obs, exp); end
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1; req = 3'b000;
    data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_live_update();
    test_reset_mid_show();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
